// File: rtl/pcs_pkg.sv
// Shared PCS constants for the multi-lane receive path.
package pcs_pkg;

  localparam int unsigned LANE_N  = 4;
  localparam int unsigned BLOCK_W = 66;
  localparam int unsigned LANE_W  = $clog2(LANE_N);

endpackage

// File: rtl/lane_reorder_mux.sv
// One output lane of the reorder crossbar: AND-OR merge of every slot whose select bit is set.
module lane_reorder_mux #(
  parameter int unsigned LANE_N  = pcs_pkg::LANE_N,
  parameter int unsigned BLOCK_W = pcs_pkg::BLOCK_W
) (
  input  logic [LANE_N-1:0]         sel,
  input  logic [LANE_N*BLOCK_W-1:0] block,
  output logic [BLOCK_W-1:0]        lane_block
);

  always_comb begin
    lane_block = '0;
    for (int unsigned i = 0; i < LANE_N; i++) begin
      lane_block = lane_block | (block[i*BLOCK_W +: BLOCK_W] & {BLOCK_W{sel[i]}});
    end
  end

endmodule

// File: rtl/lane_reorder_rx.sv
// Receive lane deskew/reorder: routes each slot's block to its logical lane, registered.
// Optional lane id checker enabled by LANE_REORDER_CHECK_EN.
module lane_reorder_rx #(
  parameter int unsigned LANE_N  = pcs_pkg::LANE_N,
  parameter int unsigned BLOCK_W = pcs_pkg::BLOCK_W
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic [LANE_N*LANE_N-1:0]  lane_i,
  input  logic [LANE_N*BLOCK_W-1:0] block_i,
  output logic [LANE_N*BLOCK_W-1:0] block_o
`ifdef LANE_REORDER_CHECK_EN
  ,
  output logic                      lane_err_o
`endif
);

  // col[j] gathers bit j of every slot's id: which slots claim output lane j
  logic [LANE_N-1:0]         col [LANE_N];
  logic [LANE_N*BLOCK_W-1:0] next_block;

  always_comb begin
    for (int unsigned j = 0; j < LANE_N; j++) begin
      col[j] = '0;
      for (int unsigned i = 0; i < LANE_N; i++) begin
        col[j][i] = lane_i[i*LANE_N + j];
      end
    end
  end

  for (genvar j = 0; j < LANE_N; j++) begin : g_lane
    lane_reorder_mux #(
      .LANE_N  (LANE_N),
      .BLOCK_W (BLOCK_W)
    ) u_mux (
      .sel        (col[j]),
      .block      (block_i),
      .lane_block (next_block[j*BLOCK_W +: BLOCK_W])
    );
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      block_o <= '0;
    end else begin
      block_o <= next_block;
    end
  end

`ifdef LANE_REORDER_CHECK_EN
  logic next_err;

  // Flags any slot id that is not one-hot and any lane not claimed exactly once
  always_comb begin
    next_err = 1'b0;
    for (int unsigned i = 0; i < LANE_N; i++) begin
      if (!$onehot(lane_i[i*LANE_N +: LANE_N])) next_err = 1'b1;
      if (!$onehot(col[i])) next_err = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      lane_err_o <= 1'b0;
    end else begin
      lane_err_o <= next_err;
    end
  end
`endif

endmodule

// File: tb/tb_lane_reorder_rx.sv
// Self-checking bench for lane_reorder_rx: table vectors, random rotations, reset corners.
module tb_lane_reorder_rx;

  localparam int N = 4;
  localparam int W = 66;

  logic           clk = 1'b0;
  logic           nreset;
  logic [N*N-1:0] lane_i;
  logic [N*W-1:0] block_i;
  logic [N*W-1:0] block_o;
  logic           lane_err_o;

  lane_reorder_rx #(
    .LANE_N  (N),
    .BLOCK_W (W)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .lane_i     (lane_i),
    .block_i    (block_i),
    .block_o    (block_o)
`ifdef LANE_REORDER_CHECK_EN
    ,
    .lane_err_o (lane_err_o)
`endif
  );

`ifndef LANE_REORDER_CHECK_EN
  assign lane_err_o = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [N*N-1:0] lane;
    logic [N*W-1:0] blk;
    logic [N*W-1:0] exp;
    logic           err;
  } vec_t;

  typedef struct {
    logic [N*W-1:0] blk;
    logic           err;
    string          name;
  } exp_t;

  vec_t  tbl [5];
  exp_t  sb [$];
  int    checks = 0;
  int    errors = 0;

  logic [W-1:0] a, b, c, d;

  function automatic logic [W-1:0] rand66();
    logic [W-1:0] r;
    r = {$urandom_range(3, 0), $urandom(), $urandom()};
    return r;
  endfunction

  task automatic check_blk(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s block_o act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic check_err(input string name, input logic act, input logic exp);
`ifdef LANE_REORDER_CHECK_EN
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane_err_o act=%b exp=%b", name, act, exp);
    end
`endif
  endtask

  // Drive at negedge, push expectation, compare one cycle later
  task automatic apply(input string name, input logic [N*N-1:0] lane, input logic [N*W-1:0] blk,
                       input logic [N*W-1:0] exp, input logic err);
    exp_t e;
    @(negedge clk);
    lane_i  = lane;
    block_i = blk;
    e.blk  = exp;
    e.err  = err;
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty act=0 exp=1", name);
    end else begin
      e = sb.pop_front();
      check_blk(e.name, block_o, e.blk);
      check_err(e.name, lane_err_o, e.err);
    end
  endtask

  initial begin
    a = 66'h1_0123_4567_89AB_CDEF;
    b = 66'h2_FEDC_BA98_7654_3210;
    c = 66'h3_DEAD_BEEF_CAFE_F00D;
    d = 66'h0_5A5A_A5A5_0F0F_F0F0;

    tbl[0] = '{lane: 16'h8421, blk: {d, c, b, a}, exp: {d, c, b, a}, err: 1'b0};
    tbl[1] = '{lane: 16'h0000, blk: {a, b, c, d}, exp: '0, err: 1'b1};
    tbl[2] = '{lane: 16'h8411, blk: {d, c, 66'h00F, 66'h0F0}, exp: {d, c, 66'h0, 66'h0FF}, err: 1'b1};
    tbl[3] = '{lane: 16'h1248, blk: {d, c, b, a}, exp: {a, b, c, d}, err: 1'b0};
    tbl[4] = '{lane: 16'h0003, blk: {d, c, b, a}, exp: {66'h0, 66'h0, a, a}, err: 1'b1};

    // Reset held: outputs stay zero despite live identity traffic
    nreset  = 1'b0;
    lane_i  = 16'h8421;
    block_i = {rand66(), rand66(), rand66(), rand66()};
    repeat (3) @(posedge clk);
    #1;
    check_blk("reset_hold", block_o, '0);
    check_err("reset_hold", lane_err_o, 1'b0);
    @(negedge clk);
    nreset = 1'b1;
    #1;
    check_blk("reset_release", block_o, '0);
    apply("first_edge", 16'h8421, {d, c, b, a}, {d, c, b, a}, 1'b0);

    for (int k = 0; k < 5; k++) begin
      apply($sformatf("tbl%0d", k), tbl[k].lane, tbl[k].blk, tbl[k].exp, tbl[k].err);
    end

    // Back-to-back random rotations
    for (int k = 0; k < 10; k++) begin
      logic [N*N-1:0] lane;
      logic [N*W-1:0] blk, exp;
      int unsigned r, dst;
      logic [W-1:0] v;
      r = $urandom_range(N-1, 0);
      for (int i = 0; i < N; i++) begin
        dst = (r + i) % N;
        v = rand66();
        lane[i*N +: N] = '0;
        lane[i*N + dst] = 1'b1;
        blk[i*W +: W] = v;
        exp[dst*W +: W] = v;
      end
      apply($sformatf("rot%0d", k), lane, blk, exp, 1'b0);
    end

    // Async reset between edges clears output without a clock
    apply("pre_async", 16'h8421, {d, c, b, a}, {d, c, b, a}, 1'b0);
    #2;
    nreset = 1'b0;
    #1;
    check_blk("async_reset", block_o, '0);
    check_err("async_reset", lane_err_o, 1'b0);
    @(negedge clk);
    nreset = 1'b1;
    apply("post_async", 16'h1248, {d, c, b, a}, {a, b, c, d}, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/lane_reorder_rx.md
Name: lane_reorder_rx

Overview:
- Receive-side lane deskew/reorder stage of the multi-lane (40G/100G-style) PCS.
- Each physical input slot carries a 66-bit block plus a one-hot logical lane id, recovered upstream from alignment markers.
- The block routes each block to the output position given by its lane id, restoring logical lane order for downstream descrambling/decoding.
- Outputs are registered: one-cycle latency.

Parameters:
- LANE_N, 4, number of lanes; must be ≥2.
- BLOCK_W, 66, block width in bits (2-bit sync header + 64-bit payload).

Ports:
- clk  input  1  system clock.
- nreset  input  1  asynchronous active-low reset.
- lane_i  input  LANE_N*LANE_N  per-slot one-hot lane id; slot i occupies bits [i*LANE_N +: LANE_N]; bit j set = slot i belongs to logical lane j.
- block_i  input  LANE_N*BLOCK_W  per-slot block; slot i occupies bits [i*BLOCK_W +: BLOCK_W].
- block_o  output  LANE_N*BLOCK_W  reordered blocks; logical lane j occupies bits [j*BLOCK_W +: BLOCK_W].
- lane_err_o  output  1  lane id error flag; present only with LANE_REORDER_CHECK_EN.

Behaviour:
- Reset: nreset low clears block_o to all zeros asynchronously (and lane_err_o to 0). Outputs stay 0 until the first rising clk after reset is released.
- Crossbar: for each output lane j, next_block[j] = bitwise OR over slots i of (lane_i[i][j] ? block_i[i] : 0).
- Implement as an AND-OR one-hot mux. No priority encoder, no X propagation.
- Latency: block_o is the registered version of next_block, updated on every rising clk edge. No enable and no handshake; every cycle is accepted.
- Valid permutation: lane ids one-hot and mutually distinct → block_o[j] = block_i[i] where lane_i[i] = 1<<j, exactly one cycle later.
- Slot with all-zero lane id contributes nothing. All slots zero → block_o = 0 (defined value, never X).
- Output lane claimed by no slot → that output lane = 0.
- Two slots claiming the same lane → that output lane is the bitwise OR of both blocks. This is not corrected and is only reported by the optional check.
- Slot with multiple bits set drives the same block to every claimed lane (OR-merged with any other claimant).
- Changing lane_i mid-stream takes effect on the next edge; no stored mapping.
- Reset asserted mid-operation clears outputs immediately. Data in flight is dropped.

Optional Feature:
- Macro: LANE_REORDER_CHECK_EN.
- Defined:
  - lane_err_o port exists and is registered alongside block_o (same one-cycle latency, reset 0).
  - It asserts when any slot's lane id is not exactly one-hot (zero or multiple bits), or when any logical lane is claimed by a number of slots other than one.
  - Data path behaviour is unchanged.
- Undefined: lane_err_o and its logic are absent. Data path is identical.

Decomposition:
- Shared package pcs_pkg holds LANE_N, BLOCK_W and the derived LANE_W = $clog2(LANE_N).
- One natural sub-module: lane_reorder_mux, a combinational one-hot AND-OR selector producing one output lane from all slots.
- lane_reorder_rx instantiates LANE_N copies of lane_reorder_mux plus the output register.
- lane_reorder_rx also holds the optional checker.

Test Plan:
- Reset: hold nreset=0 with random block_i and lane_i = identity → block_o = 0 and lane_err_o = 0; after release, the first edge loads the identity mapping.
- No valid ids: lane_i = 0, random block_i → after one clk, block_o = 0 and lane_err_o = 1.
- Identity: lane_i slots = {0001, 0010, 0100, 1000}, block_i slots = {A, B, C, D} → block_o lanes = {A, B, C, D} one cycle later.
- Rotations: ten cycles, each using a random starting lane r with slot i = 1<<((r+i)%4), random 66-bit blocks → block_o[(r+i)%4] == block_i[i] for every i, checked one cycle later. Back-to-back mapping changes must track every cycle.
- Duplicate: slots 0 and 1 both 0001 with blocks 0x...F0 and 0x...0F → lane0 = 0x...FF, the unclaimed lane = 0, lane_err_o = 1.
- Async reset mid-stream: pulse nreset low between clock edges → block_o = 0 immediately, with no wait for clk.
